// File: rtl/esm_pkg.sv
// esm_pkg: shared types and constants for the ESM instruction buffer blocks.
package esm_pkg;

  localparam int ESM_BS     = 16;
  localparam int ESM_REGNUM = 32;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    WAIT   = 2'd1,
    PEND   = 2'd2,
    ISSUED = 2'd3
  } slot_state_t;

  typedef logic [ESM_BS-1:0] slot_vec_t;

  // Index width for a slot vector of bs entries (at least one bit).
  function automatic int slot_idx_width(input int bs);
    return (bs > 1) ? $clog2(bs) : 1;
  endfunction

endpackage

// File: rtl/dep_issue_scheduler_if.sv
// dep_issue_scheduler_if: alloc / issue / complete handshakes and status of
// the issue scheduler. master = decode/execute side, slave = scheduler.
interface dep_issue_scheduler_if #(
  parameter int BS = esm_pkg::ESM_BS
);
  localparam int IW = esm_pkg::slot_idx_width(BS);

  logic          alloc_valid;
  logic          alloc_ready;
  logic [IW-1:0] alloc_index;
  logic [BS-1:0] alloc_idt;
  logic          issue_valid;
  logic          issue_ready;
  logic [IW-1:0] issue_index;
  logic          complete_valid;
  logic [IW-1:0] complete_index;
  logic [IW:0]   count;
  logic          empty;
  logic          full;
  logic          protocol_err;

  modport master (
    output alloc_valid, alloc_idt, issue_ready, complete_valid, complete_index,
    input  alloc_ready, alloc_index, issue_valid, issue_index, count, empty,
           full, protocol_err
  );

  modport slave (
    input  alloc_valid, alloc_idt, issue_ready, complete_valid, complete_index,
    output alloc_ready, alloc_index, issue_valid, issue_index, count, empty,
           full, protocol_err
  );

endinterface

// File: rtl/sched_rr_pick.sv
// sched_rr_pick: combinational pick of the first requester at or after a
// start pointer, wrapping modulo N (N must be a power of two).
module sched_rr_pick #(
  parameter int N = 16,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] grant,
  output logic          any
);

  logic [IW-1:0] idx_s;

  // Scan from the far end back towards start so the nearest requester wins.
  always_comb begin
    grant = {IW{1'b0}};
    idx_s = {IW{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      idx_s = start + IW'(k);
      grant = req[idx_s] ? idx_s : grant;
    end
  end

  assign any = |req;

endmodule

// File: rtl/dep_issue_scheduler.sv
// dep_issue_scheduler: owns the instruction-buffer slots, stores each entry's
// dependency row and issues entries whose dependencies have all completed.
// Build option: SCHED_AGE_ORDER_EN selects oldest-first issue via an age
// matrix; without it selection is round-robin from rr_ptr.
module dep_issue_scheduler
  import esm_pkg::*;
#(
  parameter int BS = ESM_BS,
  localparam int IW = $clog2(BS)
) (
  input  logic clk,
  input  logic rst,
  dep_issue_scheduler_if.slave bus
);

  localparam logic [BS-1:0] BIT0 = {{(BS-1){1'b0}}, 1'b1};

  slot_state_t   state_r [BS];
  logic [BS-1:0] dep_r   [BS];
  logic [BS-1:0] row_pend_r;
  logic          wr_pend_r;
  logic [IW-1:0] wr_idx_r;
  logic          issue_valid_r;
  logic [IW-1:0] issue_index_r;
  logic [IW:0]   count_r;
  logic          empty_r;
  logic          full_r;
  logic          perr_r;

  logic [BS-1:0] free_s;
  logic [BS-1:0] occ_s;
  logic [BS-1:0] cand_s;
  logic [BS-1:0] comp_bit_s;
  logic [BS-1:0] clr_col_s;
  logic [BS-1:0] row_val_s;
  logic [BS-1:0] row_set_s;
  logic [BS-1:0] row_clr_s;
  logic [BS-1:0] pick_req_s;
  logic [IW-1:0] alloc_index_s;
  logic [IW-1:0] pick_start_s;
  logic [IW-1:0] pick_idx_s;
  logic          pick_any_s;
  logic          alloc_ready_s;
  logic          alloc_hs_s;
  logic          issue_hs_s;
  logic          load_s;
  logic          complete_ok_s;
  logic          complete_bad_s;
  logic [IW:0]   count_nxt_s;

  // Per-slot occupancy and issue candidacy; a column completing this cycle
  // already counts as cleared so the dependant can load on this edge.
  always_comb begin
    free_s = {BS{1'b0}};
    cand_s = {BS{1'b0}};
    for (int i = 0; i < BS; i++) begin
      free_s[i] = (state_r[i] == FREE);
      cand_s[i] = (state_r[i] == WAIT) && ((dep_r[i] & ~clr_col_s) == {BS{1'b0}})
                  && !row_pend_r[i];
    end
  end

  // Lowest-numbered free slot is offered for allocation.
  always_comb begin
    alloc_index_s = {IW{1'b0}};
    for (int i = BS - 1; i >= 0; i--) begin
      alloc_index_s = free_s[i] ? IW'(i) : alloc_index_s;
    end
  end

  assign occ_s          = ~free_s;
  assign alloc_ready_s  = |free_s;
  assign alloc_hs_s     = bus.alloc_valid & alloc_ready_s;
  assign issue_hs_s     = issue_valid_r & bus.issue_ready;
  assign load_s         = ~issue_valid_r | bus.issue_ready;
  assign comp_bit_s     = bus.complete_valid ? (BIT0 << bus.complete_index) : {BS{1'b0}};
  assign complete_ok_s  = bus.complete_valid && (state_r[bus.complete_index] == ISSUED);
  assign complete_bad_s = bus.complete_valid && !complete_ok_s;
  assign clr_col_s      = complete_ok_s ? comp_bit_s : {BS{1'b0}};
  // Stale table bits for free, self or just-completing slots are dropped.
  assign row_val_s      = bus.alloc_idt & occ_s & ~(BIT0 << wr_idx_r) & ~comp_bit_s;
  assign row_set_s      = alloc_hs_s ? (BIT0 << alloc_index_s) : {BS{1'b0}};
  assign row_clr_s      = wr_pend_r ? (BIT0 << wr_idx_r) : {BS{1'b0}};
  assign count_nxt_s    = count_r + {{IW{1'b0}}, alloc_hs_s} - {{IW{1'b0}}, complete_ok_s};

`ifdef SCHED_AGE_ORDER_EN
  logic [BS-1:0] older_r [BS];
  logic [BS-1:0] oldest_s;

  // Keep only candidates that no other candidate is older than.
  always_comb begin
    oldest_s = cand_s;
    for (int i = 0; i < BS; i++) begin
      for (int j = 0; j < BS; j++) begin
        if (cand_s[j] && older_r[j][i]) begin
          oldest_s[i] = 1'b0;
        end else begin
          oldest_s[i] = oldest_s[i];
        end
      end
    end
  end

  assign pick_req_s   = oldest_s;
  assign pick_start_s = {IW{1'b0}};

  // Age matrix: a new entry is younger than every slot occupied when it arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BS; i++) older_r[i] <= {BS{1'b0}};
    end else if (alloc_hs_s) begin
      for (int j = 0; j < BS; j++) begin
        if (IW'(j) == alloc_index_s) older_r[j] <= {BS{1'b0}};
        else older_r[j][alloc_index_s] <= occ_s[j];
      end
    end
  end
`else
  logic [IW-1:0] rr_ptr_r;

  assign pick_req_s = cand_s;
  // Forward the pointer update so a reload right after a handshake already
  // starts past the entry just accepted.
  assign pick_start_s = issue_hs_s ? (issue_index_r + IW'(1)) : rr_ptr_r;

  // Round-robin pointer follows the last accepted issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_r <= {IW{1'b0}};
    else if (issue_hs_s) rr_ptr_r <= issue_index_r + IW'(1);
  end
`endif

  sched_rr_pick #(.N(BS)) u_pick (
    .req   (pick_req_s),
    .start (pick_start_s),
    .grant (pick_idx_s),
    .any   (pick_any_s)
  );

  // Slot lifecycle; alloc, load, handshake and completion touch distinct slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BS; i++) state_r[i] <= FREE;
    end else begin
      if (alloc_hs_s)           state_r[alloc_index_s]      <= WAIT;
      if (load_s && pick_any_s) state_r[pick_idx_s]         <= PEND;
      if (issue_hs_s)           state_r[issue_index_r]      <= ISSUED;
      if (complete_ok_s)        state_r[bus.complete_index] <= FREE;
    end
  end

  // Track the slot whose dependency row arrives one cycle after allocation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend_r  <= 1'b0;
      wr_idx_r   <= {IW{1'b0}};
      row_pend_r <= {BS{1'b0}};
    end else begin
      wr_pend_r  <= alloc_hs_s;
      wr_idx_r   <= alloc_index_s;
      row_pend_r <= (row_pend_r & ~row_clr_s) | row_set_s;
    end
  end

  // Dependency rows: write the arriving row, clear the completed column elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BS; i++) dep_r[i] <= {BS{1'b0}};
    end else begin
      for (int i = 0; i < BS; i++) begin
        if (wr_pend_r && (wr_idx_r == IW'(i))) dep_r[i] <= row_val_s;
        else dep_r[i] <= dep_r[i] & ~clr_col_s;
      end
    end
  end

  // Issue register: reload whenever empty or being accepted; hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid_r <= 1'b0;
      issue_index_r <= {IW{1'b0}};
    end else if (load_s) begin
      issue_valid_r <= pick_any_s;
      if (pick_any_s) issue_index_r <= pick_idx_s;
    end
  end

  // Occupancy counter and registered empty/full flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {(IW+1){1'b0}};
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      empty_r <= (count_nxt_s == {(IW+1){1'b0}});
      full_r  <= (count_nxt_s == (IW+1)'(BS));
    end
  end

  // Sticky protocol error on completion of a slot that was not issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr_r <= 1'b0;
    else if (complete_bad_s) perr_r <= 1'b1;
  end

  assign bus.alloc_ready  = alloc_ready_s;
  assign bus.alloc_index  = alloc_index_s;
  assign bus.issue_valid  = issue_valid_r;
  assign bus.issue_index  = issue_index_r;
  assign bus.count        = count_r;
  assign bus.empty        = empty_r;
  assign bus.full         = full_r;
  assign bus.protocol_err = perr_r;

endmodule

// File: tb/tb_dep_issue_scheduler.sv
// tb_dep_issue_scheduler: directed tests of allocation, dependency release,
// backpressure, full handling, same-cycle masking and protocol errors.
module tb_dep_issue_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  dep_issue_scheduler_if #(.BS(16)) bus ();

  dep_issue_scheduler #(.BS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %0b want 0", bus.issue_valid); end
    checks++; if (bus.issue_index !== 4'd0) begin errors++; $display("FAIL reset_issue_index: got %0d want 0", bus.issue_index); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", bus.full); end
    checks++; if (bus.protocol_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %0b want 0", bus.protocol_err); end
    checks++; if (bus.alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %0b want 1", bus.alloc_ready); end
    checks++; if (bus.alloc_index !== 4'd0) begin errors++; $display("FAIL reset_alloc_index: got %0d want 0", bus.alloc_index); end
  endtask

  task automatic test_basic();
    bus.issue_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.alloc_valid = 1'b1;
      checks++; if (bus.alloc_index !== 4'(k)) begin errors++; $display("FAIL basic_alloc_index: got %0d want %0d", bus.alloc_index, k); end
      checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL basic_early_issue: got %0b want 0", bus.issue_valid); end
      step();
      bus.alloc_idt = 16'h0000;
    end
    bus.alloc_valid = 1'b0;
    checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL basic_count3: got %0d want 3", bus.count); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.issue_valid !== 1'b1 || bus.issue_index !== 4'(k)) begin errors++; $display("FAIL basic_issue: got v=%0b idx=%0d want v=1 idx=%0d", bus.issue_valid, bus.issue_index, k); end
      step();
    end
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %0b want 0", bus.issue_valid); end
    for (int k = 0; k < 3; k++) begin
      bus.complete_valid = 1'b1;
      bus.complete_index = 4'(k);
      step();
      checks++; if (bus.count !== 5'(2 - k)) begin errors++; $display("FAIL basic_count_dec: got %0d want %0d", bus.count, 2 - k); end
    end
    bus.complete_valid = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL basic_empty: got %0b want 1", bus.empty); end
  endtask

  task automatic test_chain();
    bus.issue_ready = 1'b1;
    bus.alloc_valid = 1'b1;
    step();
    bus.alloc_idt = 16'h0000;
    step();
    bus.alloc_idt = 16'h0001;
    step();
    bus.alloc_valid = 1'b0;
    bus.alloc_idt = 16'h0002;
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_index !== 4'd0) begin errors++; $display("FAIL chain_first: got v=%0b idx=%0d want v=1 idx=0", bus.issue_valid, bus.issue_index); end
    step();
    bus.alloc_idt = 16'h0000;
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL chain_blocked_a: got %0b want 0", bus.issue_valid); end
    step();
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL chain_blocked_b: got %0b want 0", bus.issue_valid); end
    for (int k = 0; k < 2; k++) begin
      bus.complete_valid = 1'b1;
      bus.complete_index = 4'(k);
      step();
      bus.complete_valid = 1'b0;
      checks++; if (bus.issue_valid !== 1'b1 || bus.issue_index !== 4'(k + 1)) begin errors++; $display("FAIL chain_release: got v=%0b idx=%0d want v=1 idx=%0d", bus.issue_valid, bus.issue_index, k + 1); end
      step();
      checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL chain_single: got %0b want 0", bus.issue_valid); end
    end
    bus.complete_valid = 1'b1;
    bus.complete_index = 4'd2;
    step();
    bus.complete_valid = 1'b0;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL chain_count: got %0d want 0", bus.count); end
  endtask

  task automatic test_back_to_back();
    bus.issue_ready = 1'b0;
    bus.alloc_idt   = 16'h0000;
    bus.alloc_valid = 1'b1;
    step();
    step();
    bus.alloc_valid = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.issue_valid !== 1'b1 || bus.issue_index !== 4'd0) begin errors++; $display("FAIL bp_hold: got v=%0b idx=%0d want v=1 idx=0", bus.issue_valid, bus.issue_index); end
      step();
    end
    checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL bp_count: got %0d want 2", bus.count); end
    bus.issue_ready = 1'b1;
    step();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_index !== 4'd1) begin errors++; $display("FAIL bp_second: got v=%0b idx=%0d want v=1 idx=1", bus.issue_valid, bus.issue_index); end
    step();
    checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b want 0", bus.issue_valid); end
    for (int k = 0; k < 2; k++) begin
      bus.complete_valid = 1'b1;
      bus.complete_index = 4'(k);
      step();
    end
    bus.complete_valid = 1'b0;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL bp_count_end: got %0d want 0", bus.count); end
  endtask

  task automatic test_full();
    bus.issue_ready = 1'b1;
    bus.alloc_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checks++; if (bus.alloc_index !== 4'(k)) begin errors++; $display("FAIL full_alloc_index: got %0d want %0d", bus.alloc_index, k); end
      step();
      bus.alloc_idt = 16'h0000;
    end
    checks++; if (bus.full !== 1'b1 || bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL full_flags: got full=%0b ready=%0b want full=1 ready=0", bus.full, bus.alloc_ready); end
    repeat (10) step();
    checks++; if (bus.count !== 5'd16 || bus.full !== 1'b1) begin errors++; $display("FAIL full_ignore: got count=%0d full=%0b want 16/1", bus.count, bus.full); end
    bus.complete_valid = 1'b1;
    bus.complete_index = 4'd5;
    checks++; if (bus.alloc_ready !== 1'b0) begin errors++; $display("FAIL full_same_cycle: got %0b want 0", bus.alloc_ready); end
    step();
    bus.complete_valid = 1'b0;
    checks++; if (bus.alloc_ready !== 1'b1 || bus.alloc_index !== 4'd5 || bus.count !== 5'd15) begin errors++; $display("FAIL full_reuse: got ready=%0b idx=%0d count=%0d want 1/5/15", bus.alloc_ready, bus.alloc_index, bus.count); end
    step();
    bus.alloc_valid = 1'b0;
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL full_refill: got %0d want 16", bus.count); end
    repeat (6) step();
    for (int k = 0; k < 16; k++) begin
      bus.complete_valid = 1'b1;
      bus.complete_index = 4'(k);
      step();
    end
    bus.complete_valid = 1'b0;
    checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL full_drain: got count=%0d empty=%0b want 0/1", bus.count, bus.empty); end
  endtask

  task automatic test_same_cycle_complete();
    bus.issue_ready = 1'b1;
    bus.alloc_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      bus.alloc_idt = 16'h0000;
    end
    bus.alloc_valid = 1'b0;
    repeat (8) step();
    bus.alloc_valid = 1'b1;
    checks++; if (bus.alloc_index !== 4'd4) begin errors++; $display("FAIL same_alloc_index: got %0d want 4", bus.alloc_index); end
    step();
    bus.alloc_valid    = 1'b0;
    bus.alloc_idt      = 16'h0008;
    bus.complete_valid = 1'b1;
    bus.complete_index = 4'd3;
    step();
    bus.complete_valid = 1'b0;
    bus.alloc_idt      = 16'h0000;
    checks++; if (bus.issue_valid !== 1'b0 || bus.count !== 5'd4) begin errors++; $display("FAIL same_mid: got v=%0b count=%0d want 0/4", bus.issue_valid, bus.count); end
    step();
    checks++; if (bus.issue_valid !== 1'b1 || bus.issue_index !== 4'd4) begin errors++; $display("FAIL same_issue: got v=%0b idx=%0d want v=1 idx=4", bus.issue_valid, bus.issue_index); end
    step();
    for (int k = 0; k < 5; k++) begin
      if (k != 3) begin
        bus.complete_valid = 1'b1;
        bus.complete_index = 4'(k);
        step();
      end
    end
    bus.complete_valid = 1'b0;
    checks++; if (bus.count !== 5'd0 || bus.protocol_err !== 1'b0) begin errors++; $display("FAIL same_drain: got count=%0d perr=%0b want 0/0", bus.count, bus.protocol_err); end
  endtask

  task automatic test_bad_completion();
    checks++; if (bus.protocol_err !== 1'b0) begin errors++; $display("FAIL bad_pre: got %0b want 0", bus.protocol_err); end
    bus.alloc_valid = 1'b1;
    step();
    bus.alloc_valid = 1'b0;
    step();
    bus.complete_valid = 1'b1;
    bus.complete_index = 4'd7;
    step();
    bus.complete_valid = 1'b0;
    checks++; if (bus.protocol_err !== 1'b1 || bus.count !== 5'd1) begin errors++; $display("FAIL bad_flag: got perr=%0b count=%0d want 1/1", bus.protocol_err, bus.count); end
    repeat (3) step();
    checks++; if (bus.protocol_err !== 1'b1) begin errors++; $display("FAIL bad_sticky: got %0b want 1", bus.protocol_err); end
    rst = 1'b1;
    #1;
    checks++; if (bus.protocol_err !== 1'b0 || bus.count !== 5'd0 || bus.issue_valid !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL bad_rst: got perr=%0b count=%0d v=%0b empty=%0b want 0/0/0/1", bus.protocol_err, bus.count, bus.issue_valid, bus.empty); end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    bus.alloc_valid    = 1'b0;
    bus.alloc_idt      = 16'h0000;
    bus.issue_ready    = 1'b0;
    bus.complete_valid = 1'b0;
    bus.complete_index = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_chain();
    test_back_to_back();
    test_full();
    test_same_cycle_complete();
    test_bad_completion();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
